aes_key_schedule: RTL and testbench

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule.sv | 187 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
`default_nettype none
//==============================================================================
// Module      : aes_key_schedule
// Description : AES-128 key expansion. One shared forward S-box substitutes a
//               single byte per cycle; the 11 round keys are kept in a local
//               buffer that is read through a registered, 1-cycle read port.
// Revision    : 1.0 - initial release
//==============================================================================
module aes_key_schedule (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         KS_START,
    input  logic [127:0] AES_KEY,
    output logic         KS_BUSY,
    output logic         KS_DONE,
    input  logic [3:0]   RK_IDX,
    output logic [127:0] RK_DATA
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] c_last_round = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SUB     = 3'd2,
        ST_COMBINE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t         r_state;
    logic [3:0]     r_round;
    logic [1:0]     r_byte;
    logic [127:0]   r_prev;       // previous round key {w[4k-4] .. w[4k-1]}
    logic [31:0]    r_sub;        // SubWord(RotWord(w[4k-1])) being assembled
    logic [127:0]   r_rk [0:10];

    logic [31:0]    w_rot_word;
    logic [7:0]     w_sub_in;
    logic [7:0]     w_sub_out;
    logic [31:0]    w_t;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;

    // Round constant for rounds 1..10.
    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    assign w_rot_word = {r_prev[23:0], r_prev[31:24]};

    // Pick the byte of RotWord(w[4k-1]) handled this cycle, MSB first.
    always_comb begin
        w_sub_in = w_rot_word[31:24];
        case (r_byte)
            2'd0: w_sub_in = w_rot_word[31:24];
            2'd1: w_sub_in = w_rot_word[23:16];
            2'd2: w_sub_in = w_rot_word[15:8];
            2'd3: w_sub_in = w_rot_word[7:0];
            default: w_sub_in = w_rot_word[31:24];
        endcase
    end

    // Entry n lives at bit offset 8*(255-n); 255-n is simply ~n for a byte.
    assign w_sub_out = c_sbox[{~w_sub_in, 3'b000} +: 8];

    // Next round key words, chained from the previous round key.
    assign w_t  = r_sub ^ {f_rcon(r_round), 24'h000000};
    assign w_n0 = r_prev[127:96] ^ w_t;
    assign w_n1 = w_n0 ^ r_prev[95:64];
    assign w_n2 = w_n1 ^ r_prev[63:32];
    assign w_n3 = w_n2 ^ r_prev[31:0];

    // Expansion FSM with registered status outputs and round-key buffer writes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
            r_byte  <= 2'd0;
            r_prev  <= '0;
            r_sub   <= '0;
            KS_BUSY <= 1'b0;
            KS_DONE <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (KS_START) begin
                        r_state <= ST_LOAD;
                        KS_BUSY <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_rk[0] <= AES_KEY;
                    r_prev  <= AES_KEY;
                    r_round <= 4'd1;
                    r_byte  <= 2'd0;
                    r_state <= ST_SUB;
                end
                ST_SUB: begin
                    case (r_byte)
                        2'd0: r_sub[31:24] <= w_sub_out;
                        2'd1: r_sub[23:16] <= w_sub_out;
                        2'd2: r_sub[15:8]  <= w_sub_out;
                        2'd3: r_sub[7:0]   <= w_sub_out;
                        default: r_sub[31:24] <= w_sub_out;
                    endcase
                    r_byte <= r_byte + 2'd1;
                    if (r_byte == 2'd3) begin
                        r_state <= ST_COMBINE;
                    end
                end
                ST_COMBINE: begin
                    r_rk[r_round] <= {w_n0, w_n1, w_n2, w_n3};
                    r_prev        <= {w_n0, w_n1, w_n2, w_n3};
                    if (r_round == c_last_round) begin
                        r_state <= ST_DONE;
                        KS_BUSY <= 1'b0;
                        KS_DONE <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_state <= ST_SUB;
                    end
                end
                ST_DONE: begin
                    if (!KS_START) begin
                        r_state <= ST_IDLE;
                        KS_DONE <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    KS_BUSY <= 1'b0;
                    KS_DONE <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port; a same-cycle write is seen one read later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RK_DATA <= '0;
        end else begin
            RK_DATA <= (RK_IDX <= c_last_round) ? r_rk[RK_IDX] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
//==============================================================================
// Module      : tb_aes_key_schedule
// Description : Self-checking bench for aes_key_schedule. A reference expansion
//               (S-box derived from GF(2^8) inverse + affine map) feeds a
//               scoreboard queue that is drained against the read port.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_aes_key_schedule;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         KS_START;
    logic [127:0] AES_KEY;
    logic         KS_BUSY;
    logic         KS_DONE;
    logic [3:0]   RK_IDX;
    logic [127:0] RK_DATA;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];
    logic [127:0] sb_q [$];

    localparam logic [127:0] c_fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_fips_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_zero_rk1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .KS_START (KS_START),
        .AES_KEY  (AES_KEY),
        .KS_BUSY  (KS_BUSY),
        .KS_DONE  (KS_DONE),
        .RK_IDX   (RK_IDX),
        .RK_DATA  (RK_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] av;
        logic [7:0] bv;
        for (int a = 0; a < 256; a++) begin
            av  = a[7:0];
            inv = 8'h00;
            if (av != 8'h00) begin
                for (int b = 1; b < 256; b++) begin
                    bv = b[7:0];
                    if (gmul(av, bv) == 8'h01) inv = bv;
                end
            end
            sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Called at a drive point (cycle 0); the next rising edge is edge 0.
    task automatic run_exp(input logic [127:0] key, input int drop_at, input int pulse_at,
                           input int abort_at, input bit chk_idx3, input bit chk_clr);
        int done_cyc;
        done_cyc = 0;
        AES_KEY  = key;
        KS_START = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(posedge CLK);
            #1;
            if (c == 2) AES_KEY = ~key;
            if (c == drop_at) KS_START = 1'b0;
            if (pulse_at > 0 && c == pulse_at) KS_START = 1'b1;
            if (pulse_at > 0 && c == pulse_at + 1) KS_START = 1'b0;
            if (chk_idx3 && c == 15) RK_IDX = 4'd3;
            if (c == abort_at) begin
                #1 RESET = 1'b1;
                #1;
                check("abort_busy", 128'(KS_BUSY), 128'd0);
                check("abort_done", 128'(KS_DONE), 128'd0);
                check("abort_rkdata", RK_DATA, 128'd0);
                return;
            end
            @(negedge CLK);
            if (c == 1) check("busy_load", 128'(KS_BUSY), 128'd1);
            if (c == 1 && chk_clr) check("rk10_cleared", RK_DATA, 128'd0);
            if (c == 30) check("busy_mid", 128'(KS_BUSY), 128'd1);
            if (chk_idx3 && c == 16) check("rk3_c16", RK_DATA, 128'd0);
            if (chk_idx3 && c == 17) check("rk3_c17_old", RK_DATA, 128'd0);
            if (chk_idx3 && c == 18) check("rk3_c18_new", RK_DATA, exp_rk[3]);
            if (done_cyc == 0 && KS_DONE) begin
                done_cyc = c;
                check("busy_at_done", 128'(KS_BUSY), 128'd0);
            end else if (done_cyc != 0 && c == done_cyc + 1) begin
                if (KS_START) check("done_hold", 128'(KS_DONE), 128'd1);
                else          check("done_to_idle", 128'(KS_DONE), 128'd0);
                break;
            end
        end
        check("done_cycle", 128'(done_cyc), 128'd52);
    endtask

    // Back-to-back reads of every index; expectations queued at drive time.
    task automatic sweep(input string name);
        logic [127:0] want;
        for (int i = 0; i <= 16; i++) begin
            @(posedge CLK);
            #1;
            if (i <= 15) begin
                RK_IDX = i[3:0];
                sb_q.push_back(i <= 10 ? exp_rk[i] : 128'd0);
            end
            @(negedge CLK);
            if (i >= 1) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("%s_qempty%0d", name, i - 1), 128'd1, 128'd0);
                end else begin
                    want = sb_q.pop_front();
                    check($sformatf("%s_rk%0d", name, i - 1), RK_DATA, want);
                end
            end
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
        @(posedge CLK);
        #1 RK_IDX = idx;
        @(posedge CLK);
        @(negedge CLK);
        data = RK_DATA;
    endtask

    initial begin
        logic [127:0] d;
        RESET    = 1'b1;
        KS_START = 1'b0;
        AES_KEY  = '0;
        RK_IDX   = 4'd0;
        build_sbox();

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 128'(KS_BUSY), 128'd0);
        check("rst_done", 128'(KS_DONE), 128'd0);
        check("rst_rkdata", RK_DATA, 128'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Run 1: FIPS key, START held, RK_IDX=3 watched around its write
        expand(c_fips_key);
        run_exp(c_fips_key, 0, 0, 0, 1'b1, 1'b0);
        sweep("fips");
        read_rk(4'd1, d);  check("fips_rk1", d, c_fips_rk1);
        read_rk(4'd10, d); check("fips_rk10", d, c_fips_rk10);
        @(posedge CLK);
        #1 KS_START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("drop_idle", 128'(KS_DONE), 128'd0);

        // Run 2: zero key, START dropped in cycle 3, glitch high in cycle 20
        @(posedge CLK);
        #1;
        expand(128'd0);
        run_exp(128'd0, 3, 20, 0, 1'b0, 1'b0);
        sweep("zero");
        read_rk(4'd1, d);  check("zero_rk1", d, c_zero_rk1);
        read_rk(4'd10, d); check("zero_rk10", d, c_zero_rk10);

        // Run 3: abort by reset in cycle 30, START high across release
        @(posedge CLK);
        #1 RK_IDX = 4'd10;
        run_exp(c_fips_key, 0, 0, 30, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("hold_rst_busy", 128'(KS_BUSY), 128'd0);
        check("hold_rst_rkdata", RK_DATA, 128'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        expand(c_fips_key);
        run_exp(c_fips_key, 0, 0, 0, 1'b0, 1'b1);
        sweep("rerun");
        read_rk(4'd1, d);  check("rerun_rk1", d, c_fips_rk1);
        read_rk(4'd10, d); check("rerun_rk10", d, c_fips_rk10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
